// File: rtl/latch_pkg.sv
// Shared state encoding, default geometry and a helper for sizing the latch loader.
package latch_pkg;

    typedef enum logic [2:0] {IDLE, SHIFT, SETUP, GATE, HOLD, DONE} state_t;

    localparam int DEF_W         = 8;
    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_GATE_CYC  = 2;
    localparam int DEF_HOLD_CYC  = 1;

    function automatic int phase_max(input int x, input int y, input int z);
        int m;
        m = (x > y) ? x : y;
        return (m > z) ? m : z;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter; expired is high once the loaded count has run out.
module phase_timer #(
    parameter int TW = 2
) (
    input  logic          c,
    input  logic          r_n,
    input  logic          load,
    input  logic [TW-1:0] val,
    output logic          expired
);

    logic [TW-1:0] cnt;

    always_ff @(posedge c or negedge r_n) begin
        if (!r_n)            cnt <= '0;
        else if (load)       cnt <= val;
        else if (cnt != '0)  cnt <= cnt - 1'b1;
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/latch_loader.sv
// Serial-to-parallel loader that presents a word to a latch bank and strobes its gate
// with programmable setup, gate and hold phases.
module latch_loader
    import latch_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int GATE_CYC  = DEF_GATE_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic         c,
    input  logic         r_n,
    input  logic         si,
    input  logic         sv,
    output logic         srdy,
    input  logic         clr,
    output logic [W-1:0] d,
    output logic         g,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(W);
    localparam int TW = $clog2(phase_max(SETUP_CYC, GATE_CYC, HOLD_CYC) + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  sr;
    logic          take, last;
    logic          tmr_load, tmr_exp;
    logic [TW-1:0] tmr_val;

    // srdy is only ever high in IDLE/SHIFT, so it alone qualifies acceptance.
    assign take = sv && srdy && !clr;
    assign last = take && (cnt == CW'(W - 1));
    assign busy = (state == SETUP) || (state == GATE) || (state == HOLD) || (state == DONE);

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (last) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(SETUP_CYC - 1);
        end else if (state == SETUP && tmr_exp) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(GATE_CYC - 1);
        end else if (state == GATE && tmr_exp) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(HOLD_CYC - 1);
        end
    end

    phase_timer #(.TW(TW)) u_timer (
        .c       (c),
        .r_n     (r_n),
        .load    (tmr_load),
        .val     (tmr_val),
        .expired (tmr_exp)
    );

    always_ff @(posedge c or negedge r_n) begin
        if (!r_n) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
            d     <= '0;
            g     <= 1'b0;
            done  <= 1'b0;
            srdy  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, SHIFT: begin
                    srdy <= 1'b1;
                    if (clr) begin
                        state <= IDLE;
                        cnt   <= '0;
                        sr    <= '0;
                    end else if (take) begin
                        sr <= {si, sr[W-1:1]};
                        if (last) begin
                            cnt   <= '0;
                            d     <= {si, sr[W-1:1]};
                            state <= SETUP;
                            srdy  <= 1'b0;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= SHIFT;
                        end
                    end
                end
                SETUP: if (tmr_exp) begin
                    state <= GATE;
                    g     <= 1'b1;
                end
                GATE: if (tmr_exp) begin
                    state <= HOLD;
                    g     <= 1'b0;
                end
                HOLD: if (tmr_exp) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    srdy  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    g     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_loader.sv
// Randomized bench for two latch_loader configurations against a transaction-level model.
module tb_latch_loader;

    logic       c, r_n;
    logic [1:0] si, sv, clr, srdy, g, busy, done;
    logic [7:0] d0;
    logic [3:0] d1;

    latch_loader u0 (
        .c(c), .r_n(r_n), .si(si[0]), .sv(sv[0]), .srdy(srdy[0]), .clr(clr[0]),
        .d(d0), .g(g[0]), .busy(busy[0]), .done(done[0])
    );

    latch_loader #(.W(4), .SETUP_CYC(3), .GATE_CYC(1), .HOLD_CYC(2)) u1 (
        .c(c), .r_n(r_n), .si(si[1]), .sv(sv[1]), .srdy(srdy[1]), .clr(clr[1]),
        .d(d1), .g(g[1]), .busy(busy[1]), .done(done[1])
    );

    initial c = 1'b0;
    always #5 c = ~c;

    typedef struct {
        int          k;
        logic [31:0] word;
        int          n;
    } exp_t;

    exp_t        sb[$];
    int          nchk = 0;
    int          nerr = 0;
    int          ecnt = 0;
    logic [31:0] bits[2];
    logic [31:0] m_d[2];
    int          nbits[2];
    int          unlock[2];
    bit          m_rdy[2];

    function automatic int wv(input int k); return (k == 0) ? 8 : 4; endfunction
    function automatic int sc(input int k); return (k == 0) ? 1 : 3; endfunction
    function automatic int gc(input int k); return (k == 0) ? 2 : 1; endfunction
    function automatic int hc(input int k); return (k == 0) ? 1 : 2; endfunction
    function automatic int tt(input int k); return sc(k) + gc(k) + hc(k); endfunction
    function automatic logic [31:0] dval(input int k);
        return (k == 0) ? 32'(d0) : 32'(d1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            bits[k]   = '0;
            nbits[k]  = 0;
            m_d[k]    = '0;
            m_rdy[k]  = 1'b0;
            unlock[k] = ecnt + 1;
        end
        sb.delete();
    endtask

    // Word-level model: a bit counts when the loader is ready and no clear is pending;
    // a complete word locks the loader for the whole phase sequence.
    task automatic model_edge(input int k);
        if (!r_n) begin
            unlock[k] = ecnt + 1;
            return;
        end
        if (m_rdy[k] && clr[k]) begin
            bits[k]  = '0;
            nbits[k] = 0;
        end else if (m_rdy[k] && sv[k]) begin
            bits[k] = bits[k] | (32'(si[k]) << nbits[k]);
            nbits[k]++;
            if (nbits[k] == wv(k)) begin
                m_d[k] = bits[k];
                sb.push_back('{k: k, word: bits[k], n: ecnt});
                bits[k]   = '0;
                nbits[k]  = 0;
                unlock[k] = ecnt + tt(k) + 1;
            end
        end
        m_rdy[k] = (ecnt >= unlock[k]);
    endtask

    task automatic step();
        @(posedge c);
        ecnt++;
        for (int k = 0; k < 2; k++) model_edge(k);
        #1;
    endtask

    task automatic idle(input int n);
        sv  = '0;
        clr = '0;
        repeat (n) step();
    endtask

    task automatic send_bits(input int k, input logic [31:0] word, input int n);
        for (int i = 0; i < n; i++) begin
            si[k] = word[i];
            sv[k] = 1'b1;
            step();
        end
        sv[k] = 1'b0;
    endtask

    task automatic flush(input int k);
        idle(tt(k) + 2);
        clr[k] = 1'b1;
        step();
        clr[k] = 1'b0;
        step();
    endtask

    for (genvar k = 0; k < 2; k++) begin : mon
        always @(negedge c) begin
            if (r_n) begin
                chk("srdy", 32'(srdy[k]), 32'(m_rdy[k]));
                chk("d", dval(k), m_d[k]);
                if (sb.size() > 0 && sb[0].k == k) begin
                    int e;
                    e = ecnt - sb[0].n;
                    chk("g", 32'(g[k]), 32'(e >= sc(k) && e < sc(k) + gc(k)));
                    chk("done", 32'(done[k]), 32'(e == tt(k)));
                    chk("busy", 32'(busy[k]), 32'(e <= tt(k)));
                    if (done[k]) begin
                        chk("word", dval(k), sb[0].word);
                        void'(sb.pop_front());
                    end else if (e >= tt(k)) begin
                        void'(sb.pop_front());
                    end
                end else begin
                    chk("g_idle", 32'(g[k]), 32'd0);
                    chk("done_idle", 32'(done[k]), 32'd0);
                    chk("busy_idle", 32'(busy[k]), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        nerr++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        si = '0; sv = '0; clr = '0;
        r_n = 1'b1;
        #1 r_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_srdy", 32'(srdy[k]), 32'd0);
            chk("rst_g", 32'(g[k]), 32'd0);
            chk("rst_d", dval(k), 32'd0);
            chk("rst_done", 32'(done[k]), 32'd0);
            chk("rst_busy", 32'(busy[k]), 32'd0);
        end
        step(); step();
        r_n = 1'b1;
        step();
        chk("srdy_first_edge", 32'(srdy[0]), 32'd1);

        // basic word
        send_bits(0, 32'h4D, 8);
        idle(tt(0) + 2);
        chk("d_4d", dval(0), 32'h4D);

        // clear of a partial word leaves d alone
        send_bits(0, 32'h5, 3);
        clr[0] = 1'b1; step(); clr[0] = 1'b0;
        chk("d_keep", dval(0), 32'h4D);
        send_bits(0, 32'hFF, 8);
        idle(tt(0) + 2);
        chk("d_ff", dval(0), 32'hFF);

        // sv held high across a busy transaction
        sv[0] = 1'b1;
        repeat (2 * 8 + tt(0) + 6) begin
            si[0] = 1'($urandom_range(0, 1));
            step();
        end
        sv[0] = 1'b0;
        flush(0);

        // clr during the phase sequence is ignored
        send_bits(0, 32'hA5, 8);
        clr[0] = 1'b1;
        repeat (tt(0)) step();
        clr[0] = 1'b0;
        idle(3);
        chk("d_a5", dval(0), 32'hA5);

        // random traffic, default configuration
        repeat (300) begin
            sv[0]  = 1'($urandom_range(0, 1));
            si[0]  = 1'($urandom_range(0, 1));
            clr[0] = ($urandom_range(0, 19) == 0);
            step();
        end
        flush(0);

        // reset in the middle of the gate pulse
        send_bits(0, 32'h3C, 8);
        step();
        chk("g_before_rst", 32'(g[0]), 32'd1);
        #2 r_n = 1'b0;
        model_reset();
        #1;
        chk("rst_gate_g", 32'(g[0]), 32'd0);
        chk("rst_gate_d", dval(0), 32'd0);
        chk("rst_gate_srdy", 32'(srdy[0]), 32'd0);
        chk("rst_gate_done", 32'(done[0]), 32'd0);
        step();
        r_n = 1'b1;
        step();
        chk("srdy_release", 32'(srdy[0]), 32'd1);
        idle(2);

        // narrow configuration
        send_bits(1, 32'hA, 4);
        idle(tt(1) + 2);
        chk("d1_a", dval(1), 32'hA);
        repeat (250) begin
            sv[1]  = 1'($urandom_range(0, 1));
            si[1]  = 1'($urandom_range(0, 1));
            clr[1] = ($urandom_range(0, 19) == 0);
            step();
        end
        flush(1);
        send_bits(1, 32'h6, 4);
        idle(tt(1) + 3);
        chk("d1_6", dval(1), 32'h6);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/latch_loader.md
LATCH_LOADER -- requirements
Module: latch_loader

Interface
REQ-001 Parameter W, 8, data width of the word presented to the downstream dc_trigger latch bank; legal range 2..32.
REQ-002 Parameter SETUP_CYC, 1, cycles the d bus is stable before the gate rises; minimum 1.
REQ-003 Parameter GATE_CYC, 2, cycles the gate is high; minimum 1.
REQ-004 Parameter HOLD_CYC, 1, cycles the d bus is stable after the gate falls; minimum 1.
REQ-005 c  input  1  the block's only clock; all state updates occur on its rising edge.
REQ-006 r_n  input  1  asynchronous, active-low reset.
REQ-007 si  input  1  serial data bit, LSB first.
REQ-008 sv  input  1  si valid.
REQ-009 srdy  output  1  block ready to accept a serial bit.
REQ-010 clr  input  1  synchronous discard of a partially assembled word.
REQ-011 d  output  W  parallel word to the latch-bank d inputs.
REQ-012 g  output  1  latch-bank enable, driving the dc_trigger c inputs.
REQ-013 busy  output  1  high in states SETUP, GATE, HOLD and DONE.
REQ-014 done  output  1  one-cycle pulse when a latch transaction completes.

Function
REQ-015 States: IDLE, SHIFT, SETUP, GATE, HOLD, DONE.
REQ-016 A bit is accepted on a rising edge of c where sv=1 and srdy=1; sv while srdy=0 is ignored and has no side effects.
REQ-017 srdy=1 only in IDLE and SHIFT; srdy is registered.
REQ-018 Accepted bits fill the internal shift register LSB first; bit count cnt is 0..W-1.
REQ-019 Transitions: IDLE->SHIFT on the first accepted bit; SHIFT->SETUP on the W-th accepted bit, with cnt wrapping to 0.
REQ-020 d is loaded from the shift register only on entry to SETUP; d holds that value through SETUP, GATE, HOLD and DONE, and afterwards until the next SETUP entry.
REQ-021 Phase timing: SETUP lasts SETUP_CYC cycles, GATE lasts GATE_CYC cycles, HOLD lasts HOLD_CYC cycles, and DONE lasts exactly 1 cycle, after which the state returns to IDLE.
REQ-022 g is registered and glitch-free; g=1 exactly in GATE.
REQ-023 Latency: if the last bit is accepted at edge N, d is valid after N, g rises at N+SETUP_CYC, g falls at N+SETUP_CYC+GATE_CYC, done is high for the cycle after edge N+S+G+H, and srdy=1 from edge N+S+G+H+1.
REQ-024 clr in IDLE or SHIFT sends the state to IDLE and zeroes cnt and the shift register; d is unchanged.
REQ-025 clr in SETUP, GATE, HOLD or DONE is ignored; a latch transaction is atomic.
REQ-026 If clr and an accepted bit occur on the same edge, clr wins and the bit is discarded.
REQ-027 done=1 only in DONE; busy is decoded from the registered state.

Reset
REQ-028 On r_n=0, asynchronously: state=IDLE, cnt=0, shift register=0, d=0, g=0, done=0, busy=0, srdy=0.
REQ-029 srdy rises on the first rising edge of c after r_n is released.
REQ-030 Reset asserted during GATE drops g immediately, with no completion pulse.

Structure
REQ-031 Package latch_pkg holds the state enumeration and the default W, SETUP_CYC, GATE_CYC and HOLD_CYC constants.
REQ-032 One sub-module, phase_timer, is a loadable down-counter that signals expiry of the SETUP, GATE and HOLD phases.
REQ-033 The timer width is derived from the largest phase parameter.

Verification
REQ-034 Defaults; shift bits 1,0,1,1,0,0,1,0 with sv held high -> d=8'h4D; g high for 2 cycles starting 1 cycle after the 8th bit; done pulses once; srdy returns high.
REQ-035 3 bits accepted, then clr -> state IDLE, d keeps its prior value; the next 8 bits 8'hFF -> d=8'hFF.
REQ-036 sv held high throughout SETUP..DONE -> no bits accepted; the following word is assembled uncorrupted.
REQ-037 clr asserted during GATE -> ignored; g width remains 2 cycles; done asserted.
REQ-038 r_n pulsed low in mid-GATE -> g=0, d=0, srdy=0 immediately; srdy=1 one edge after release.
REQ-039 W=4, SETUP_CYC=3, GATE_CYC=1, HOLD_CYC=2; word 4'hA -> d=4'hA; g rises 3 cycles after the last bit, lasts 1 cycle, and done is high 2 cycles later.
